// File: rtl/read_iq_pkg.sv
// Shared constants, state encoding and quantizer for the IQ byte front-end.
package read_iq_pkg;

  localparam int QUANT_BITS_DEF = 10;

  typedef logic [2:0] iq_state_t;

  localparam iq_state_t S_I_LO  = 3'd0;
  localparam iq_state_t S_I_HI  = 3'd1;
  localparam iq_state_t S_Q_LO  = 3'd2;
  localparam iq_state_t S_Q_HI  = 3'd3;
  localparam iq_state_t S_WRITE = 3'd4;

  // Sign-extend to 32 bits before shifting; no saturation.
  function automatic logic [31:0] quantize16(input logic [15:0] x16, input int qb);
    logic signed [31:0] ext;
    ext = {{16{x16[15]}}, x16};
    return 32'(ext <<< qb);
  endfunction

endpackage

// File: rtl/read_iq_if.sv
// Byte-FIFO read side plus the two sample-FIFO write sides of the IQ front-end.
interface read_iq_if;
  logic [7:0]  in_dout;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] i_din;
  logic        i_wr_en;
  logic        i_full;
  logic [31:0] q_din;
  logic        q_wr_en;
  logic        q_full;

  modport master (
    input  in_dout, in_empty, i_full, q_full,
    output in_rd_en, i_din, i_wr_en, q_din, q_wr_en
  );

  modport slave (
    output in_dout, in_empty, i_full, q_full,
    input  in_rd_en, i_din, i_wr_en, q_din, q_wr_en
  );
endinterface

// File: rtl/read_iq.sv
// Pops little-endian IQ bytes, assembles int16 I/Q, quantizes and pushes both
// sample FIFOs together.
//   state   | meaning
//   S_I_LO  | waiting to pop I low byte
//   S_I_HI  | waiting to pop I high byte
//   S_Q_LO  | waiting to pop Q low byte
//   S_Q_HI  | waiting to pop Q high byte; pop also registers quantized I/Q
//   S_WRITE | push I and Q together once neither FIFO is full
module read_iq
  import read_iq_pkg::*;
#(
  parameter int QUANT_BITS = QUANT_BITS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  read_iq_if.master  bus
);

  if (QUANT_BITS > 16) begin : g_qb_check
    $error("read_iq: QUANT_BITS must be <= 16 to fit a 32-bit sample");
  end

  iq_state_t   r_state;
  iq_state_t   w_state_nxt;
  logic [7:0]  r_i_lo;
  logic [7:0]  r_i_hi;
  logic [7:0]  r_q_lo;
  logic [31:0] r_i_din;
  logic [31:0] r_q_din;
  logic        w_pop;
  logic        w_write;

  // Pop is gated by reset so the byte FIFO is left untouched while held in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      S_I_LO, S_I_HI, S_Q_LO, S_Q_HI: begin
        w_pop = !bus.in_empty && !reset;
        if (w_pop) begin
          w_state_nxt = (r_state == S_Q_HI) ? S_WRITE : r_state + 3'd1;
        end
      end
      S_WRITE: begin
        w_write = !bus.i_full && !bus.q_full;
        if (w_write) begin
          w_state_nxt = S_I_LO;
        end
      end
      default: w_state_nxt = S_I_LO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_I_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_i_lo  <= 8'h00;
      r_i_hi  <= 8'h00;
      r_q_lo  <= 8'h00;
      r_i_din <= 32'h0;
      r_q_din <= 32'h0;
    end else if (w_pop) begin
      case (r_state)
        S_I_LO: r_i_lo <= bus.in_dout;
        S_I_HI: r_i_hi <= bus.in_dout;
        S_Q_LO: r_q_lo <= bus.in_dout;
        S_Q_HI: begin
          r_i_din <= quantize16({r_i_hi, r_i_lo}, QUANT_BITS);
          r_q_din <= quantize16({bus.in_dout, r_q_lo}, QUANT_BITS);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_rd_en = w_pop;
  assign bus.i_wr_en  = w_write;
  assign bus.q_wr_en  = w_write;
  assign bus.i_din    = r_i_din;
  assign bus.q_din    = r_q_din;

endmodule

// File: tb/tb_read_iq.sv
// Scoreboard bench for read_iq: a byte-FIFO model feeds the DUT, every group of four
// consumed bytes yields an expected I/Q pair, and a monitor checks each write.
module tb_read_iq;

  localparam int QB = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  read_iq_if bus ();

  read_iq #(.QUANT_BITS(QB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  in_q[$];
  int          in_rd = 0;
  logic [7:0]  popped[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_q[$];
  int          rd_idx = 0;

  bit force_empty = 0;
  bit rand_mode   = 0;
  bit full_i      = 0;
  bit full_q      = 0;
  bit pop_pend    = 0;

  int          cyc         = 0;
  int          grp_start   = 0;
  int          last_wr_cyc = 0;
  int          n_writes    = 0;
  logic [31:0] last_i      = 0;
  logic [31:0] last_q      = 0;

  // Reference: int16 from two bytes, scaled by 2^QB with plain integer arithmetic.
  function automatic logic [31:0] model_q(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = int'(hi) * 256 + int'(lo);
    if (v >= 32768) v = v - 65536;
    return 32'(v * (1 << QB));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte FIFO / sample FIFO environment: drive at negedge, decide the pop just before posedge.
  always @(negedge clock) begin
    if (rand_mode) begin
      force_empty = ($urandom_range(3) == 0);
      full_i      = ($urandom_range(4) == 0);
      full_q      = ($urandom_range(4) == 0);
    end
    bus.in_empty = force_empty || (in_rd >= in_q.size());
    bus.in_dout  = (in_rd < in_q.size()) ? in_q[in_rd] : 8'h00;
    bus.i_full   = full_i;
    bus.q_full   = full_q;
    #4;
    pop_pend = bus.in_rd_en && !bus.in_empty;
  end

  always @(posedge clock) begin
    if (reset) begin
      popped.delete();
    end else if (pop_pend && in_rd < in_q.size()) begin
      if (popped.size() == 0) grp_start = cyc;
      popped.push_back(in_q[in_rd]);
      in_rd++;
      if (popped.size() == 4) begin
        exp_i.push_back(model_q(popped[0], popped[1]));
        exp_q.push_back(model_q(popped[2], popped[3]));
        popped.delete();
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    #1;
    if (bus.in_rd_en && bus.in_empty) chk("rd_when_empty", 32'(bus.in_rd_en), 32'd0);
    if (bus.i_wr_en || bus.q_wr_en) begin
      chk("wr_pair", 32'({bus.i_wr_en, bus.q_wr_en}), 32'd3);
      chk("wr_while_full", 32'({bus.i_full, bus.q_full}), 32'd0);
      chk("rd_during_wr", 32'(bus.in_rd_en), 32'd0);
      if (rd_idx < exp_i.size()) begin
        chk("i_din", bus.i_din, exp_i[rd_idx]);
        chk("q_din", bus.q_din, exp_q[rd_idx]);
      end else begin
        chk("sb_underflow", 32'(exp_i.size()), 32'(rd_idx + 1));
      end
      rd_idx++;
      last_i      = bus.i_din;
      last_q      = bus.q_din;
      last_wr_cyc = cyc;
      n_writes++;
    end
  end

  task automatic wait_writes(input int n, input int budget, input string name);
    int k = 0;
    while (n_writes < n && k < budget) begin
      @(posedge clock); #1;
      k++;
    end
    checks++;
    if (n_writes < n) begin
      errors++;
      $display("FAIL %s timeout: writes %0d need %0d", name, n_writes, n);
    end
  endtask

  task automatic wait_pops(input int n, input string name);
    int k = 0;
    @(posedge clock); #1;
    while (popped.size() != n && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    checks++;
    if (popped.size() != n) begin
      errors++;
      $display("FAIL %s timeout: popped %0d need %0d", name, popped.size(), n);
    end
  endtask

  task automatic wait_exp(input int n, input string name);
    int k = 0;
    while (exp_i.size() < n && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    checks++;
    if (exp_i.size() < n) begin
      errors++;
      $display("FAIL %s timeout: samples %0d need %0d", name, exp_i.size(), n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b[6];
    int base;

    bus.in_dout  = 8'h00;
    bus.in_empty = 1'b1;
    bus.i_full   = 1'b0;
    bus.q_full   = 1'b0;

    // Reset state, with bytes already waiting so in_rd_en gating is visible.
    in_q.push_back(8'h34); in_q.push_back(8'h12);
    in_q.push_back(8'hCD); in_q.push_back(8'hAB);
    repeat (3) @(negedge clock);
    #2;
    chk("rst_rd_en", 32'(bus.in_rd_en), 32'd0);
    chk("rst_wr_en", 32'({bus.i_wr_en, bus.q_wr_en}), 32'd0);
    chk("rst_i_din", bus.i_din, 32'h0);
    chk("rst_q_din", bus.q_din, 32'h0);
    @(posedge clock); #2;
    reset = 1'b0;

    // Basic sample; write lands in the fifth cycle counting the first pop as cycle one.
    wait_writes(1, 50, "s1");
    chk("s1_i", last_i, 32'h0048D000);
    chk("s1_q", last_q, 32'hFEAF3400);
    chk("s1_latency", 32'(last_wr_cyc - grp_start), 32'd4);

    // int16 extremes.
    in_q.push_back(8'h00); in_q.push_back(8'h80);
    in_q.push_back(8'hFF); in_q.push_back(8'h7F);
    wait_writes(2, 50, "s2");
    chk("s2_i", last_i, 32'hFE000000);
    chk("s2_q", last_q, 32'h01FFFC00);

    // Back-pressure: I full for 7 cycles, then Q full for 2, then both free.
    full_i = 1'b1;
    in_q.push_back(8'h78); in_q.push_back(8'h56);
    in_q.push_back(8'h21); in_q.push_back(8'h43);
    for (int i = 0; i < 4; i++) in_q.push_back(8'($urandom_range(255)));
    wait_exp(3, "s3_fill");
    for (int i = 0; i < 9; i++) begin
      @(negedge clock); #2;
      chk("s3_rd_en", 32'(bus.in_rd_en), 32'd0);
      chk("s3_wr_en", 32'({bus.i_wr_en, bus.q_wr_en}), 32'd0);
      chk("s3_i_hold", bus.i_din, 32'h0159E000);
      chk("s3_q_hold", bus.q_din, 32'h010C8400);
      if (i == 6) begin full_i = 1'b0; full_q = 1'b1; end
      if (i == 8) full_q = 1'b0;
    end
    wait_writes(4, 100, "s3");

    // Input underflow between I_hi and Q_lo only stalls.
    in_q.push_back(8'h34); in_q.push_back(8'h12);
    wait_pops(2, "s4_pops");
    force_empty = 1'b1;
    in_q.push_back(8'hCD); in_q.push_back(8'hAB);
    repeat (3) begin
      @(negedge clock); #2;
      chk("s4_rd_en", 32'(bus.in_rd_en), 32'd0);
    end
    force_empty = 1'b0;
    wait_writes(5, 50, "s4");
    chk("s4_i", last_i, 32'h0048D000);
    chk("s4_q", last_q, 32'hFEAF3400);

    // Async reset mid-sample discards the partial bytes.
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom_range(255));
    for (int i = 0; i < 4; i++) in_q.push_back(b[i]);
    wait_pops(2, "s5_pops");
    #1 reset = 1'b1;
    #1;
    chk("s5_rd_en", 32'(bus.in_rd_en), 32'd0);
    chk("s5_wr_en", 32'({bus.i_wr_en, bus.q_wr_en}), 32'd0);
    chk("s5_i_din", bus.i_din, 32'h0);
    chk("s5_q_din", bus.q_din, 32'h0);
    @(posedge clock); #2;
    reset = 1'b0;
    in_q.push_back(b[4]); in_q.push_back(b[5]);
    wait_writes(6, 50, "s5");
    chk("s5_i", last_i, model_q(b[2], b[3]));
    chk("s5_q", last_q, model_q(b[4], b[5]));

    // Random bytes with random empty/full stalls.
    base = n_writes;
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) in_q.push_back(8'($urandom_range(255)));
    wait_writes(base + 250, 30000, "s6");
    rand_mode   = 1'b0;
    force_empty = 1'b0;
    full_i      = 1'b0;
    full_q      = 1'b0;
    repeat (10) @(negedge clock);
    chk("s6_pairs", 32'(n_writes - base), 32'd250);
    chk("s6_sb_left", 32'(exp_i.size() - rd_idx), 32'd0);
    chk("s6_bytes_left", 32'(in_q.size() - in_rd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
